regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the register file's single write port (WE3/A3/WD3) between two
//  writeback requesters: req0 = ALU, req1 = load/multi-cycle unit.
//  Round-robin grant per cycle. Output is registered toward the register file.
//  Holds a busy scoreboard of destination registers, which drives the
//  read-hazard stall for the decode stage.
// PARAMETERS
//  DATA_W  32  writeback data width
//  ADDR_W  5   register address width (matches A1/A2/A3)
//  NREGS   16  implemented registers; x0 is hardwired zero
// PORTS
//  CLK          in   1       clock; all state changes on posedge
//  reset_n      in   1       asynchronous, active-low reset
//  req0_valid   in   1       ALU write request
//  req0_addr    in   ADDR_W  ALU destination rd
//  req0_data    in   DATA_W  ALU result
//  req0_ready   out  1       grant; transfer when valid & ready
//  req1_valid   in   1       load-unit write request
//  req1_addr    in   ADDR_W  load destination rd
//  req1_data    in   DATA_W  load data
//  req1_ready   out  1       grant; transfer when valid & ready
//  alloc_valid  in   1       decode issues instruction with pending rd
//  alloc_rd     in   ADDR_W  rd being reserved
//  rs1, rs2     in   ADDR_W  source regs of instruction in decode
//  rs1_busy     out  1       rs1 has pending write (comb.)
//  rs2_busy     out  1       rs2 has pending write (comb.)
//  WE3          out  1       register-file write enable (registered)
//  A3           out  ADDR_W  register-file write address (registered)
//  WD3          out  DATA_W  register-file write data (registered)
//  err_range    out  1       sticky: write/alloc to addr >= NREGS seen
// BEHAVIOUR
//  Reset (async, reset_n=0): WE3=0, A3=0, WD3=0, busy[]=0, rr_ptr=0,
//   err_range=0. Any in-flight write is dropped; requesters re-present.
//  Arbitration (comb.), one grant per cycle:
//   - Only one valid: it gets ready=1.
//   - Both valid: grant req[rr_ptr]; other ready=0 and must hold stable.
//   - rr_ptr flips to the loser only on a contended grant; else unchanged.
//   - ready is never asserted without its valid.
//  Output register: on posedge with a transfer, load WE3 = (addr!=0 &&
//   addr<NREGS), A3 = addr, WD3 = data. With no transfer, WE3<=0 and A3/WD3 hold.
//   Latency: accepted at edge N -> WE3 high during cycle N..N+1.
//   The register file commits at the negedge inside that cycle.
//  Back-to-back: one transfer per cycle sustained; no internal buffering,
//   no backpressure beyond losing arbitration.
//  Scoreboard busy[1:NREGS-1]:
//   - set at posedge when alloc_valid && alloc_rd!=0 && alloc_rd<NREGS.
//   - clear at the posedge ending a WE3=1 cycle for A3, so the data
//     is in the file before busy drops.
//   - same-edge set and clear of one reg: set wins.
//   - alloc to an already-busy reg: stays busy (no count).
//  rsN_busy = (rsN!=0 && rsN<NREGS) ? busy[rsN] : 0. x0 is never busy.
//  Addr >= NREGS on a granted write or an alloc: transfer still completes,
//   WE3=0, and err_range is set until reset.
//  Write to x0: accepted (ready=1) and dropped (WE3=0).
// TESTING
//  1 reset_n=0 mid-write (WE3=1) -> WE3=0, busy=0, err_range=0 immediately.
//  2 req0 only, x5=32'hDEADBEEF -> ready0=1; next cycle WE3=1, A3=5, WD3=DEADBEEF.
//    The following cycle WE3=0.
//  3 both valid 4 cycles, rr_ptr=0 -> grants 0,1,0,1.
//    The loser's addr/data are held and written later, unchanged.
//  4 alloc x7; rs1=7 -> rs1_busy=1 until the edge after WE3 for A3=7.
//    Same edge: alloc x7 + retire x7 -> busy stays 1.
//  5 req1 addr=0, data=32'h1 -> ready1=1, WE3 stays 0. alloc/rs1=0 -> rs1_busy=0.
//  6 req0 addr=20 (NREGS=16) -> accepted, WE3=0, err_range=1 until reset.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Purpose:
//   Shares the register file's single write port (WE3/A3/WD3) between two
//   writeback requesters: req0 is the ALU and req1 is the load/multi-cycle
//   unit. One request is granted per cycle, round-robin on contention. The
//   granted write is registered before it reaches the register file.
//   A busy scoreboard of destination registers drives the decode-stage
//   read-hazard stall (rs1_busy / rs2_busy).
//
// Handshake (req0/req1):
//   A transfer happens on a rising CLK edge when valid && ready are both high.
//   ready is a combinational grant and is never high without its valid. A
//   requester that is not granted keeps valid high and addr/data stable until
//   it is granted. The only backpressure is losing arbitration.
//
// Ports:
//   CLK, reset_n              clock, asynchronous active-low reset
//   req0_valid/addr/data/ready ALU write request and grant
//   req1_valid/addr/data/ready load-unit write request and grant
//   alloc_valid, alloc_rd     decode reserves a destination register
//   rs1, rs2                  decode source registers
//   rs1_busy, rs2_busy        source has a pending write (combinational)
//   WE3, A3, WD3              registered register-file write port
//   err_range                 sticky: a write or alloc addressed >= NREGS
//   dbg_rr_ptr                round-robin pointer (priority on contention)
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREGS  = 16
) (
  input  logic              CLK,
  input  logic              reset_n,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              alloc_valid,
  input  logic [ADDR_W-1:0] alloc_rd,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              WE3,
  output logic [ADDR_W-1:0] A3,
  output logic [DATA_W-1:0] WD3,
  output logic              err_range,
  output logic              dbg_rr_ptr
);

  // NREGS widened by one bit so the range compare never truncates.
  localparam logic [ADDR_W:0] NREGS_A = (ADDR_W+1)'(NREGS);

  // Address names an implemented register (x0 included).
  function automatic logic in_file(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < NREGS_A);
  endfunction

  // Address names a register that actually stores data (x0 excluded).
  function automatic logic writable(input logic [ADDR_W-1:0] a);
    return (a != '0) && in_file(a);
  endfunction

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  // rr_ptr names the requester that wins the next contended cycle.
  logic              rr_ptr;
  logic              contended;
  logic              transfer;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;

  always_comb begin
    contended  = req0_valid && req1_valid;
    req0_ready = req0_valid && (!req1_valid || (rr_ptr == 1'b0));
    req1_ready = req1_valid && (!req0_valid || (rr_ptr == 1'b1));
    transfer   = req0_ready || req1_ready;
    win_addr   = req1_ready ? req1_addr : req0_addr;
    win_data   = req1_ready ? req1_data : req0_data;
  end

  // On contention the pointer moves to the loser so it wins next time.
  // Uncontended grants leave it alone.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= 1'b0;
    end else if (contended) begin
      rr_ptr <= ~rr_ptr;
    end
  end

  assign dbg_rr_ptr = rr_ptr;

  // ---------------------------------------------------------------------------
  // Registered write port
  // ---------------------------------------------------------------------------
  // A3/WD3 capture every accepted transfer, including dropped ones (x0 or out
  // of range), so the port shows what was accepted; only WE3 is qualified.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      WE3 <= 1'b0;
      A3  <= '0;
      WD3 <= '0;
    end else if (transfer) begin
      WE3 <= writable(win_addr);
      A3  <= win_addr;
      WD3 <= win_data;
    end else begin
      WE3 <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Busy scoreboard
  // ---------------------------------------------------------------------------
  // Bit 0 is not stored: x0 is never busy.
  logic [NREGS-1:1] busy;
  logic [NREGS-1:1] busy_next;

  // Clear is applied at the edge that ends the WE3 cycle, i.e. after the
  // register file has committed the data on the preceding negedge. The set
  // is applied after the clear so a same-edge alloc of the retiring register
  // keeps it busy for the new owner.
  always_comb begin
    busy_next = busy;
    for (int i = 1; i < NREGS; i++) begin
      if (WE3 && (A3 == ADDR_W'(i))) begin
        busy_next[i] = 1'b0;
      end
      if (alloc_valid && (alloc_rd == ADDR_W'(i))) begin
        busy_next[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  // Source lookup: x0 and out-of-range sources never match any stored bit.
  always_comb begin
    rs1_busy = 1'b0;
    rs2_busy = 1'b0;
    for (int i = 1; i < NREGS; i++) begin
      if (rs1 == ADDR_W'(i)) begin
        rs1_busy = busy[i];
      end
      if (rs2 == ADDR_W'(i)) begin
        rs2_busy = busy[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky range error
  // ---------------------------------------------------------------------------
  logic range_hit;

  always_comb begin
    range_hit = (transfer && !in_file(win_addr)) ||
                (alloc_valid && !in_file(alloc_rd));
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      err_range <= 1'b0;
    end else if (range_hit) begin
      err_range <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREGS  = 16;
  localparam int W      = ADDR_W + DATA_W;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic              CLK = 1'b0;
  logic              reset_n;
  logic              req0_valid, req1_valid, alloc_valid;
  logic [ADDR_W-1:0] req0_addr, req1_addr, alloc_rd, rs1, rs2;
  logic [DATA_W-1:0] req0_data, req1_data;
  logic              req0_ready, req1_ready, rs1_busy, rs2_busy;
  logic              WE3, err_range, dbg_rr_ptr;
  logic [ADDR_W-1:0] A3;
  logic [DATA_W-1:0] WD3;

  always #5 CLK = ~CLK;

  regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREGS(NREGS)) dut (
    .CLK(CLK), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data),
    .req1_ready(req1_ready),
    .alloc_valid(alloc_valid), .alloc_rd(alloc_rd),
    .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .WE3(WE3), .A3(A3), .WD3(WD3), .err_range(err_range),
    .dbg_rr_ptr(dbg_rr_ptr)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state and reference model
  // ---------------------------------------------------------------------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_item;
  int           n_chk = 0;
  int           n_err = 0;

  bit           m_busy[32];     // pending-write flag per architectural register
  bit           m_err;          // range error seen since reset
  int           m_prio;         // requester that wins the next tie
  bit           m_pend_v;       // a real write was accepted at the last edge
  logic [ADDR_W-1:0] m_pend_a;
  bit           last_g0, last_g1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_err    = 1'b0;
    m_prio   = 0;
    m_pend_v = 1'b0;
    m_pend_a = '0;
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: every negedge, an expected write must be on the port, or WE3 low
  // ---------------------------------------------------------------------------
  always @(negedge CLK) begin
    if (reset_n) begin
      if (exp_q.size() > 0) begin
        exp_item = exp_q.pop_front();
        chk("we3", WE3, 1);
        chk("a3", A3, exp_item[W-1:DATA_W]);
        chk("wd3", WD3, exp_item[DATA_W-1:0]);
      end else begin
        chk("we3_idle", WE3, 0);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver: one cycle. Called at a negedge with inputs already set.
  // Checks combinational outputs, predicts the next edge, then advances.
  // ---------------------------------------------------------------------------
  task automatic step();
    bit g0, g1;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    #1;
    if (req0_valid && req1_valid) begin
      g0 = (m_prio == 0);
      g1 = (m_prio == 1);
    end else begin
      g0 = req0_valid;
      g1 = req1_valid;
    end
    chk("ready0", req0_ready, g0);
    chk("ready1", req1_ready, g1);
    chk("rs1_busy", rs1_busy, m_busy[rs1]);
    chk("rs2_busy", rs2_busy, m_busy[rs2]);
    chk("err_range", err_range, m_err);
    chk("rr_ptr", dbg_rr_ptr, m_prio);

    // Effects of the coming edge: retire last write, then reserve.
    if (m_pend_v) m_busy[m_pend_a] = 1'b0;
    if (alloc_valid) begin
      if (alloc_rd >= NREGS) m_err = 1'b1;
      else if (alloc_rd != 0) m_busy[alloc_rd] = 1'b1;
    end
    m_pend_v = 1'b0;
    if (g0 || g1) begin
      wa = g0 ? req0_addr : req1_addr;
      wd = g0 ? req0_data : req1_data;
      if (wa >= NREGS) begin
        m_err = 1'b1;
      end else if (wa != 0) begin
        exp_q.push_back({wa, wd});
        m_pend_v = 1'b1;
        m_pend_a = wa;
      end
    end
    if (req0_valid && req1_valid) m_prio = g0 ? 1 : 0;
    last_g0 = g0;
    last_g1 = g1;
    @(negedge CLK);
  endtask

  function automatic logic [ADDR_W-1:0] rand_addr();
    if ($urandom_range(0, 99) < 10) return ADDR_W'($urandom_range(NREGS, 31));
    return ADDR_W'($urandom_range(0, NREGS - 1));
  endfunction

  // Granted or idle requesters may change; a waiting loser holds.
  task automatic rand_next();
    if (!req0_valid || last_g0) begin
      req0_valid = ($urandom_range(0, 99) < 60);
      req0_addr  = rand_addr();
      req0_data  = $urandom();
    end
    if (!req1_valid || last_g1) begin
      req1_valid = ($urandom_range(0, 99) < 60);
      req1_addr  = rand_addr();
      req1_data  = $urandom();
    end
    alloc_valid = ($urandom_range(0, 99) < 30);
    alloc_rd    = rand_addr();
    rs1         = rand_addr();
    rs2         = rand_addr();
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req0_addr = '0; req0_data = '0;
    req1_valid = 0; req1_addr = '0; req1_data = '0;
    alloc_valid = 0; alloc_rd = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    reset_n = 1'b0;
    idle_inputs();
    rs1 = '0; rs2 = '0;
    model_reset();
    #3;
    chk("rst_we3", WE3, 0);
    chk("rst_a3", A3, 0);
    chk("rst_wd3", WD3, 0);
    chk("rst_err", err_range, 0);
    @(negedge CLK);
    @(negedge CLK);
    reset_n = 1'b1;

    // Single ALU write to x5.
    req0_valid = 1; req0_addr = 5'd5; req0_data = 32'hDEADBEEF;
    step();
    req0_valid = 0;
    #1;
    chk("t2_we3", WE3, 1);
    chk("t2_a3", A3, 5);
    chk("t2_wd3", WD3, 32'hDEADBEEF);
    step();
    chk("t2_we3_low", WE3, 0);

    // Contention for four cycles: grants alternate starting with req0.
    req0_valid = 1; req0_addr = 5'd1; req0_data = $urandom();
    req1_valid = 1; req1_addr = 5'd2; req1_data = $urandom();
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t3_grant1", last_g1, k % 2);
      if (last_g0) begin req0_addr = 5'(3 + k); req0_data = $urandom(); end
      if (last_g1) begin req1_addr = 5'(8 + k); req1_data = $urandom(); end
    end
    req1_valid = 0;
    step();
    chk("t3_loser_drain", last_g0, 1);
    req0_valid = 0;
    step();

    // Busy scoreboard on x7, then same-edge retire + re-alloc.
    rs1 = 5'd7; rs2 = 5'd0;
    alloc_valid = 1; alloc_rd = 5'd7;
    step();
    alloc_valid = 0;
    step();
    chk("t4_busy_set", rs1_busy, 1);
    req0_valid = 1; req0_addr = 5'd7; req0_data = 32'h0000_0777;
    step();
    req0_valid = 0;
    step();
    chk("t4_busy_cleared", rs1_busy, 0);
    alloc_valid = 1; alloc_rd = 5'd7;
    step();
    alloc_valid = 0;
    req0_valid = 1; req0_addr = 5'd7; req0_data = 32'h0000_0778;
    step();
    req0_valid = 0;
    alloc_valid = 1; alloc_rd = 5'd7;
    step();
    alloc_valid = 0;
    step();
    chk("t4_set_wins", rs1_busy, 1);

    // Write to x0 and alloc of x0.
    req1_valid = 1; req1_addr = 5'd0; req1_data = 32'h1;
    alloc_valid = 1; alloc_rd = 5'd0; rs1 = 5'd0;
    step();
    req1_valid = 0; alloc_valid = 0;
    chk("t5_x0_not_busy", rs1_busy, 0);
    step();
    chk("t5_we3_low", WE3, 0);

    // Out-of-range destination.
    req0_valid = 1; req0_addr = 5'd20; req0_data = 32'hCAFE_F00D;
    step();
    req0_valid = 0;
    #1;
    chk("t6_we3_low", WE3, 0);
    chk("t6_err_set", err_range, 1);
    step();

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      rand_next();
      step();
    end

    // Drain any waiting loser, then reset in the middle of a write.
    idle_inputs();
    step();
    step();
    alloc_valid = 1; alloc_rd = 5'd9;
    step();
    alloc_valid = 0;
    req0_valid = 1; req0_addr = 5'd3; req0_data = 32'h3333_3333;
    rs1 = 5'd9;
    step();
    req0_valid = 0;
    #1;
    chk("rst_mid_we3_before", WE3, 1);
    chk("rst_mid_busy_before", rs1_busy, 1);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_we3", WE3, 0);
    chk("rst_mid_busy", rs1_busy, 0);
    chk("rst_mid_err", err_range, 0);
    chk("rst_mid_a3", A3, 0);
    model_reset();
    @(negedge CLK);
    reset_n = 1'b1;
    for (int n = 0; n < 40; n++) begin
      rand_next();
      step();
    end
    idle_inputs();
    step();
    step();
    chk("final_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
